// File: rtl/hazard_ctrl.sv
// Hazard and exception controller for the 5-stage MIPS pipeline: stalls, flushes, forward selects, PC redirect.
// Define HAZARD_PERF_CNT_EN to add per-cause 32-bit performance counters.
module hazard_ctrl #(
    parameter int          AW        = 5,
    parameter logic [31:0] RESET_VEC = 32'hBFC00000,
    parameter logic [31:0] EXC_VEC   = 32'hBFC00380,
    parameter logic [31:0] ERET_CODE = 32'h0000000E
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic [AW-1:0] rsD,
    input  logic [AW-1:0] rtD,
    input  logic          branchD,
    input  logic          jrD,
    input  logic [AW-1:0] rsE,
    input  logic [AW-1:0] rtE,
    input  logic [AW-1:0] writeregE,
    input  logic          regwriteE,
    input  logic          memtoregE,
    input  logic          longopE,
    input  logic          longop_ready,
    input  logic [AW-1:0] writeregM,
    input  logic [AW-1:0] writeregW,
    input  logic          regwriteM,
    input  logic          memtoregM,
    input  logic          regwriteW,
    input  logic          inst_stall,
    input  logic          data_stall,
    input  logic [31:0]   excepttype,
    input  logic [31:0]   epc,
    output logic          stallF,
    output logic          stallD,
    output logic          stallE,
    output logic          stallM,
    output logic          stallW,
    output logic          flushF,
    output logic          flushD,
    output logic          flushE,
    output logic          flushM,
    output logic          flushW,
    output logic [1:0]    forwardaD,
    output logic [1:0]    forwardbD,
    output logic [1:0]    forwardaE,
    output logic [1:0]    forwardbE,
    output logic          pc_redirect,
    output logic [31:0]   newpc
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]   perf_lwstall,
    output logic [31:0]   perf_longstall,
    output logic [31:0]   perf_memstall,
    output logic [31:0]   perf_exc
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PEND  = 2'b01,
        ST_BLANK = 2'b10
    } state_e;

    localparam logic [AW-1:0] ZERO_REG = {AW{1'b0}};

    state_e      state_q, state_d;
    logic [31:0] code_q, code_d;
    logic [31:0] epc_q, epc_d;

    logic        exc_raw_s, exc_now_s, exc_rel_s, exc_fire_s;
    logic        mem_tier_s, longstall_s, lwstall_s, brstall_s;
    logic [31:0] target_s;
    logic [4:0]  stall_s, flush_s;
    logic [1:0]  fad_s, fbd_s, fae_s, fbe_s;
    logic        redirect_s;
    logic [31:0] newpc_s;

    function automatic logic [1:0] fwd_sel(
        input logic [AW-1:0] src,
        input logic [AW-1:0] wreg_m,
        input logic          rw_m,
        input logic [AW-1:0] wreg_w,
        input logic          rw_w
    );
        logic [1:0] sel;
        if (src != ZERO_REG && src == wreg_m && rw_m) begin
            sel = 2'b10;
        end else if (src != ZERO_REG && src == wreg_w && rw_w) begin
            sel = 2'b01;
        end else begin
            sel = 2'b00;
        end
        return sel;
    endfunction

    function automatic logic reg_hit(
        input logic [AW-1:0] dst,
        input logic [AW-1:0] src_a,
        input logic [AW-1:0] src_b
    );
        return (dst != ZERO_REG) && (dst == src_a || dst == src_b);
    endfunction

    function automatic logic [31:0] exc_target(input logic [31:0] code, input logic [31:0] pc_epc);
        return (code == ERET_CODE) ? pc_epc : EXC_VEC;
    endfunction

    // Exceptions only act from IDLE; BLANK ignores the stale M-stage code and PEND uses the captured one
    assign exc_raw_s  = (state_q == ST_IDLE) && (excepttype != 32'h0000_0000);
    assign exc_now_s  = exc_raw_s && !data_stall;
    assign exc_rel_s  = (state_q == ST_PEND) && !data_stall;
    assign exc_fire_s = exc_now_s || exc_rel_s;
    assign target_s   = exc_rel_s ? exc_target(code_q, epc_q) : exc_target(excepttype, epc);

    assign mem_tier_s  = inst_stall || data_stall || (state_q == ST_PEND);
    assign longstall_s = longopE && !longop_ready;
    assign lwstall_s   = memtoregE && reg_hit(writeregE, rsD, rtD);
    assign brstall_s   = (branchD || jrD) &&
                         ((regwriteE && reg_hit(writeregE, rsD, rtD)) ||
                          (memtoregM && reg_hit(writeregM, rsD, rtD)));

    // Exception FSM next-state and capture of a deferred exception
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        epc_d   = epc_q;
        case (state_q)
            ST_IDLE: begin
                if (exc_raw_s && data_stall) begin
                    state_d = ST_PEND;
                    code_d  = excepttype;
                    epc_d   = epc;
                end else if (exc_raw_s) begin
                    state_d = ST_BLANK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PEND: begin
                if (!data_stall) begin
                    state_d = ST_BLANK;
                end else begin
                    state_d = ST_PEND;
                end
            end
            ST_BLANK: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // Exception FSM state and captured code/epc registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            code_q  <= 32'h0000_0000;
            epc_q   <= 32'h0000_0000;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            epc_q   <= epc_d;
        end
    end

    // Prioritised stall/flush/redirect and forward selects, all forced quiet while reset is asserted
    always_comb begin
        stall_s    = 5'b00000;
        flush_s    = 5'b00000;
        redirect_s = 1'b0;
        newpc_s    = RESET_VEC;
        fad_s      = 2'b00;
        fbd_s      = 2'b00;
        fae_s      = 2'b00;
        fbe_s      = 2'b00;
        if (!resetn) begin
            stall_s = 5'b00000;
        end else begin
            fad_s = fwd_sel(rsD, writeregM, regwriteM, writeregW, regwriteW);
            fbd_s = fwd_sel(rtD, writeregM, regwriteM, writeregW, regwriteW);
            fae_s = fwd_sel(rsE, writeregM, regwriteM, writeregW, regwriteW);
            fbe_s = fwd_sel(rtE, writeregM, regwriteM, writeregW, regwriteW);
            if (exc_fire_s) begin
                flush_s    = 5'b11111;
                redirect_s = 1'b1;
                newpc_s    = target_s;
            end else if (mem_tier_s) begin
                stall_s = 5'b11111;
            end else if (longstall_s) begin
                stall_s = 5'b11100;
                flush_s = 5'b00010;
            end else if (lwstall_s || brstall_s) begin
                stall_s = 5'b11000;
                flush_s = 5'b00100;
            end else begin
                stall_s = 5'b00000;
            end
        end
    end

    assign {stallF, stallD, stallE, stallM, stallW} = stall_s;
    assign {flushF, flushD, flushE, flushM, flushW} = flush_s;
    assign forwardaD   = fad_s;
    assign forwardbD   = fbd_s;
    assign forwardaE   = fae_s;
    assign forwardbE   = fbe_s;
    assign pc_redirect = redirect_s;
    assign newpc       = newpc_s;

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] perf_lw_q, perf_long_q, perf_mem_q, perf_exc_q;
    logic        win_mem_s, win_long_s, win_lw_s;

    assign win_mem_s  = !exc_fire_s && mem_tier_s;
    assign win_long_s = !exc_fire_s && !mem_tier_s && longstall_s;
    assign win_lw_s   = !exc_fire_s && !mem_tier_s && !longstall_s && (lwstall_s || brstall_s);

    // Per-cause counters advance only when their cause wins priority; they wrap freely
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_lw_q   <= 32'h0000_0000;
            perf_long_q <= 32'h0000_0000;
            perf_mem_q  <= 32'h0000_0000;
            perf_exc_q  <= 32'h0000_0000;
        end else begin
            perf_lw_q   <= perf_lw_q   + {31'h0000_0000, win_lw_s};
            perf_long_q <= perf_long_q + {31'h0000_0000, win_long_s};
            perf_mem_q  <= perf_mem_q  + {31'h0000_0000, win_mem_s};
            perf_exc_q  <= perf_exc_q  + {31'h0000_0000, exc_fire_s};
        end
    end

    assign perf_lwstall   = perf_lw_q;
    assign perf_longstall = perf_long_q;
    assign perf_memstall  = perf_mem_q;
    assign perf_exc       = perf_exc_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes hand-computed per-cycle expectations, a negedge monitor compares.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [4:0]  rsD, rtD, rsE, rtE, writeregE, writeregM, writeregW;
    logic        branchD, jrD, regwriteE, memtoregE, longopE, longop_ready;
    logic        regwriteM, memtoregM, regwriteW, inst_stall, data_stall;
    logic [31:0] excepttype, epc;
    logic        stallF, stallD, stallE, stallM, stallW;
    logic        flushF, flushD, flushE, flushM, flushW;
    logic [1:0]  forwardaD, forwardbD, forwardaE, forwardbE;
    logic        pc_redirect;
    logic [31:0] newpc;

    int compared   = 0;
    int mismatched = 0;

    string       name_q[$];
    logic [50:0] exp_q[$];

    localparam logic [31:0] RV = 32'hBFC00000;

    hazard_ctrl dut (
        .clk(clk), .resetn(resetn),
        .rsD(rsD), .rtD(rtD), .branchD(branchD), .jrD(jrD),
        .rsE(rsE), .rtE(rtE), .writeregE(writeregE),
        .regwriteE(regwriteE), .memtoregE(memtoregE),
        .longopE(longopE), .longop_ready(longop_ready),
        .writeregM(writeregM), .writeregW(writeregW),
        .regwriteM(regwriteM), .memtoregM(memtoregM), .regwriteW(regwriteW),
        .inst_stall(inst_stall), .data_stall(data_stall),
        .excepttype(excepttype), .epc(epc),
        .stallF(stallF), .stallD(stallD), .stallE(stallE), .stallM(stallM), .stallW(stallW),
        .flushF(flushF), .flushD(flushD), .flushE(flushE), .flushM(flushM), .flushW(flushW),
        .forwardaD(forwardaD), .forwardbD(forwardbD),
        .forwardaE(forwardaE), .forwardbE(forwardbE),
        .pc_redirect(pc_redirect), .newpc(newpc)
    );

    always #5 clk = ~clk;

    // Monitor: one expectation per cycle, compared mid-cycle away from the active edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            string       nm;
            logic [50:0] ex, act;
            nm  = name_q.pop_front();
            ex  = exp_q.pop_front();
            act = {stallF, stallD, stallE, stallM, stallW,
                   flushF, flushD, flushE, flushM, flushW,
                   forwardaD, forwardbD, forwardaE, forwardbE,
                   pc_redirect, newpc};
            compared++;
            if (act !== ex) begin
                mismatched++;
                $display("FAIL %s: got stall=%b flush=%b fwd=%b redir=%b newpc=%h, want stall=%b flush=%b fwd=%b redir=%b newpc=%h",
                         nm, act[50:46], act[45:41], act[40:33], act[32], act[31:0],
                         ex[50:46], ex[45:41], ex[40:33], ex[32], ex[31:0]);
            end
        end
    end

    task automatic expect_out(input string nm, input logic [4:0] st, input logic [4:0] fl,
                              input logic [7:0] fw, input logic rd, input logic [31:0] pc);
        name_q.push_back(nm);
        exp_q.push_back({st, fl, fw, rd, pc});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        rsD = 5'd0; rtD = 5'd0; rsE = 5'd0; rtE = 5'd0;
        writeregE = 5'd0; writeregM = 5'd0; writeregW = 5'd0;
        branchD = 1'b0; jrD = 1'b0; regwriteE = 1'b0; memtoregE = 1'b0;
        longopE = 1'b0; longop_ready = 1'b0;
        regwriteM = 1'b0; memtoregM = 1'b0; regwriteW = 1'b0;
        inst_stall = 1'b0; data_stall = 1'b0;
        excepttype = 32'h0; epc = 32'h0;
    endtask

    initial begin
        clr();
        resetn = 1'b0;
        // reset: forwarding conditions present but outputs must stay quiet
        next_cycle();
        writeregM = 5'd5; regwriteM = 1'b1; rsE = 5'd5; inst_stall = 1'b1;
        expect_out("reset_quiet", 5'b00000, 5'b00000, 8'h00, 1'b0, RV);
        next_cycle();
        resetn = 1'b1;
        clr();
        writeregM = 5'd5; regwriteM = 1'b1; rsE = 5'd5; writeregW = 5'd5; regwriteW = 1'b1;
        expect_out("fwd_M_wins", 5'b00000, 5'b00000, 8'b0000_1000, 1'b0, RV);
        next_cycle();
        rsE = 5'd0;
        expect_out("fwd_r0", 5'b00000, 5'b00000, 8'b0000_0000, 1'b0, RV);
        next_cycle();
        clr();
        writeregM = 5'd3; regwriteM = 1'b1; writeregW = 5'd7; regwriteW = 1'b1; rtE = 5'd7; rsD = 5'd3;
        expect_out("fwd_D_M_E_W", 5'b00000, 5'b00000, 8'b1000_0001, 1'b0, RV);
        next_cycle();
        clr();
        writeregM = 5'd5; regwriteM = 1'b0; writeregW = 5'd5; regwriteW = 1'b1; rsE = 5'd5;
        expect_out("fwd_W_only", 5'b00000, 5'b00000, 8'b0000_0100, 1'b0, RV);
        // load-use stall
        next_cycle();
        clr();
        memtoregE = 1'b1; regwriteE = 1'b1; writeregE = 5'd8; rsD = 5'd8;
        expect_out("lwstall", 5'b11000, 5'b00100, 8'h00, 1'b0, RV);
        next_cycle();
        clr();
        rsD = 5'd8;
        expect_out("lwstall_gone", 5'b00000, 5'b00000, 8'h00, 1'b0, RV);
        // branch stalls
        next_cycle();
        clr();
        branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd9; rtD = 5'd9;
        expect_out("brstall_E", 5'b11000, 5'b00100, 8'h00, 1'b0, RV);
        next_cycle();
        clr();
        jrD = 1'b1; memtoregM = 1'b1; regwriteM = 1'b1; writeregM = 5'd4; rsD = 5'd4;
        expect_out("brstall_M_load", 5'b11000, 5'b00100, 8'b1000_0000, 1'b0, RV);
        next_cycle();
        clr();
        branchD = 1'b1; regwriteE = 1'b1; writeregE = 5'd0;
        expect_out("brstall_r0", 5'b00000, 5'b00000, 8'h00, 1'b0, RV);
        // long op: 3 cycles, the last also a load-use hazard that it must outrank
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            clr();
            longopE = 1'b1; longop_ready = 1'b0;
            if (i == 2) begin
                memtoregE = 1'b1; writeregE = 5'd6; rtD = 5'd6;
            end
            expect_out("longstall", 5'b11100, 5'b00010, 8'h00, 1'b0, RV);
        end
        next_cycle();
        clr();
        longopE = 1'b1; longop_ready = 1'b1;
        expect_out("longstall_done", 5'b00000, 5'b00000, 8'h00, 1'b0, RV);
        // memory stall outranks long op
        next_cycle();
        clr();
        inst_stall = 1'b1; longopE = 1'b1;
        expect_out("memstall_inst", 5'b11111, 5'b00000, 8'h00, 1'b0, RV);
        // immediate exception, inst_stall does not defer it
        next_cycle();
        clr();
        excepttype = 32'h1; inst_stall = 1'b1; epc = 32'h8000_0040;
        expect_out("exc_now", 5'b00000, 5'b11111, 8'h00, 1'b1, 32'hBFC00380);
        next_cycle();
        clr();
        excepttype = 32'h1;
        expect_out("exc_blank", 5'b00000, 5'b00000, 8'h00, 1'b0, RV);
        next_cycle();
        clr();
        expect_out("exc_idle", 5'b00000, 5'b00000, 8'h00, 1'b0, RV);
        // deferred ERET: data_stall for 4 cycles, inputs change while pending
        next_cycle();
        clr();
        excepttype = 32'h0000000E; epc = 32'h8000_1234; data_stall = 1'b1;
        expect_out("defer_capture", 5'b11111, 5'b00000, 8'h00, 1'b0, RV);
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            clr();
            data_stall = 1'b1; excepttype = 32'h1; epc = 32'h1111_0000;
            expect_out("pend_stall", 5'b11111, 5'b00000, 8'h00, 1'b0, RV);
        end
        next_cycle();
        clr();
        excepttype = 32'h1; epc = 32'h1111_0000;
        expect_out("pend_release", 5'b00000, 5'b11111, 8'h00, 1'b1, 32'h8000_1234);
        next_cycle();
        clr();
        excepttype = 32'h0000000E;
        expect_out("pend_blank", 5'b00000, 5'b00000, 8'h00, 1'b0, RV);
        // reset while pending discards the captured exception
        next_cycle();
        clr();
        excepttype = 32'h1; data_stall = 1'b1;
        expect_out("defer2_capture", 5'b11111, 5'b00000, 8'h00, 1'b0, RV);
        next_cycle();
        clr();
        data_stall = 1'b1;
        expect_out("defer2_pend", 5'b11111, 5'b00000, 8'h00, 1'b0, RV);
        next_cycle();
        resetn = 1'b0;
        expect_out("reset_in_pend", 5'b00000, 5'b00000, 8'h00, 1'b0, RV);
        next_cycle();
        resetn = 1'b1;
        clr();
        expect_out("after_reset_no_redir", 5'b00000, 5'b00000, 8'h00, 1'b0, RV);
        next_cycle();
        expect_out("after_reset_idle", 5'b00000, 5'b00000, 8'h00, 1'b0, RV);

        // bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
        end
        if (exp_q.size() > 0) begin
            compared++;
            mismatched++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
